data_mem_responder: RTL

- Byte-addressed data memory acting as the responder (slave) end of a word load/store request interface.
- Serves the nano-cpu load/store path, replacing direct array indexing with a valid/ready request channel and a valid/ready response channel.
- Every access completes after a fixed, parameterised latency.
- Little-endian, word-aligned accesses with per-byte write strobes; misaligned requests get an error response.

---
 rtl/data_mem_responder_if.sv | 24 ++
 rtl/data_mem_responder.sv | 138 +++++++++++++
 2 files changed

// File: rtl/data_mem_responder_if.sv
// Word load/store request and response channels between a requester (master)
// and the data memory responder (slave).
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Byte-addressed little-endian data memory answering one aligned word access
// at a time, each completing LATENCY cycles after the request is accepted.
module data_mem_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY    = 2
) (
  input logic               clk,
  input logic               rst,
  data_mem_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state, next_state;
  logic [3:0]              cnt;
  logic                    cap_write;
  logic [ADDR_WIDTH-1:0]   cap_addr;
  logic [31:0]             cap_wdata;
  logic [3:0]              cap_wstrb;
  logic                    resp_valid_q;
  logic [31:0]             resp_rdata_q;
  logic                    resp_err_q;

  logic [7:0]              mem [0:(2**ADDR_WIDTH)-1];

  logic                    accept;
  logic                    access;
  logic                    handshake;
  logic                    misaligned;
  logic [ADDR_WIDTH-3:0]   word_idx;
  logic [31:0]             load_word;
  logic                    unused_addr_bits;

  // Upper address bits alias the memory modulo its size.
  assign unused_addr_bits = ^bus.req_addr[31:ADDR_WIDTH];

  assign misaligned = (cap_addr[1:0] != 2'b00);
  assign word_idx   = cap_addr[ADDR_WIDTH-1:2];

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    access     = 1'b0;
    handshake  = 1'b0;
    unique case (state)
      IDLE: if (bus.req_valid) begin
        accept     = 1'b1;
        next_state = WAIT;
      end
      WAIT: if (cnt == 4'd0) begin
        access     = 1'b1;
        next_state = RESP;
      end
      RESP: if (bus.resp_ready) begin
        handshake  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    load_word = '0;
    for (int i = 0; i < 4; i++) begin
      load_word[8*i +: 8] = mem[{word_idx, 2'(i)}];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt          <= '0;
      cap_write    <= 1'b0;
      cap_addr     <= '0;
      cap_wdata    <= '0;
      cap_wstrb    <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        cap_write <= bus.req_write;
        cap_addr  <= bus.req_addr[ADDR_WIDTH-1:0];
        cap_wdata <= bus.req_wdata;
        cap_wstrb <= bus.req_wstrb;
        cnt       <= 4'(LATENCY - 1);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end

      if (access) begin
        resp_valid_q <= 1'b1;
        resp_err_q   <= misaligned;
        resp_rdata_q <= (misaligned || cap_write) ? 32'd0 : load_word;
      end else if (handshake) begin
        resp_valid_q <= 1'b0;
        resp_err_q   <= 1'b0;
        resp_rdata_q <= '0;
      end
    end
  end

  // NOTE: the storage array is deliberately left out of reset so it maps onto
  // RAM; a reset during RESP therefore keeps an already committed store.
  always @(posedge clk) begin
    if (access && cap_write && !misaligned) begin
      for (int i = 0; i < 4; i++) begin
        if (cap_wstrb[i]) mem[{word_idx, 2'(i)}] <= cap_wdata[8*i +: 8];
      end
    end
  end

  // Preload and inspection hooks for simulation only.
  task read_memory_byte(input logic [31:0] address, output logic [7:0] data);
    data = mem[address[ADDR_WIDTH-1:0]];
  endtask

  task write_memory_byte(input logic [31:0] address, input logic [7:0] data);
    mem[address[ADDR_WIDTH-1:0]] <= data;
  endtask

endmodule
